// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and the arbiter that feeds it.
// The opcode values are the raw {S2,S1,S0} select codes.
package alu_pkg;

  localparam int ALU_W = 32;
  localparam int OP_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_XOR = 3'b001;
  localparam logic [OP_W-1:0] OP_INC = 3'b010;
  localparam logic [OP_W-1:0] OP_DEC = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB = 3'b101;
  localparam logic [OP_W-1:0] OP_AND = 3'b110;
  localparam logic [OP_W-1:0] OP_NOT = 3'b111;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [OP_W-1:0]  op;
    logic             ci;
  } alu_op_t;

endpackage

// File: rtl/alu_32_bit.sv
// Purely combinational 32-bit ALU. Logic ops report Co = 0; arithmetic ops
// return the carry out of bit 31 (subtract is A + ~B + Ci).
module alu_32_bit
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             Ci,
  output logic [ALU_W-1:0] F,
  output logic             Co
);

  logic [ALU_W:0] sum;
  logic [ALU_W:0] a_x;
  logic [ALU_W:0] ci_x;

  assign a_x  = {1'b0, A};
  assign ci_x = {{ALU_W{1'b0}}, Ci};

  always_comb begin
    sum = '0;
    case ({S2, S1, S0})
      OP_ADD:  sum = a_x + {1'b0, B} + ci_x;
      OP_XOR:  sum = {1'b0, A ^ B};
      OP_INC:  sum = a_x + ci_x;
      OP_DEC:  sum = a_x + {1'b0, {ALU_W{1'b1}}} + ci_x;
      OP_OR:   sum = {1'b0, A | B};
      OP_SUB:  sum = a_x + {1'b0, ~B} + ci_x;
      OP_AND:  sum = {1'b0, A & B};
      OP_NOT:  sum = {1'b0, ~A};
      default: sum = '0;
    endcase
  end

  assign F  = sum[ALU_W-1:0];
  assign Co = sum[ALU_W];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu_32_bit between two valid/ready requesters,
// with registered operands and a registered result returned per requester.
//   state | meaning
//   IDLE  | waiting for a request; grant decided combinationally
//   EXEC  | operand registers drive the ALU; result captured at the edge
//   RESP  | result held for the granted requester until it takes it
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  input  logic             req1_ci,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [ALU_W-1:0] rsp0_f,
  output logic             rsp0_co,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [ALU_W-1:0] rsp1_f,
  output logic             rsp1_co,
  output logic             busy,
  output logic             grant_id
);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             grant_id_q, grant_id_d;
  alu_op_t          opnd_q, opnd_d;
  logic [ALU_W-1:0] res_f_q, res_f_d;
  logic             res_co_q, res_co_d;
  logic [ALU_W-1:0] alu_f;
  logic             alu_co;
  logic             idle;

  // Readies are masked during reset so no handshake is ever seen that the
  // reset would silently drop.
  assign idle       = (state_q == IDLE) && rst_n;
  assign req0_ready = idle && req0_valid && (!req1_valid || !ptr_q);
  assign req1_ready = idle && req1_valid && (!req0_valid ||  ptr_q);

  alu_32_bit u_alu (
    .A  (opnd_q.a),
    .B  (opnd_q.b),
    .S0 (opnd_q.op[0]),
    .S1 (opnd_q.op[1]),
    .S2 (opnd_q.op[2]),
    .Ci (opnd_q.ci),
    .F  (alu_f),
    .Co (alu_co)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    opnd_d     = opnd_q;
    res_f_d    = res_f_q;
    res_co_d   = res_co_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          opnd_d     = '{a: req0_a, b: req0_b, op: req0_op, ci: req0_ci};
          grant_id_d = 1'b0;
          ptr_d      = 1'b1;
          state_d    = EXEC;
        end else if (req1_ready) begin
          opnd_d     = '{a: req1_a, b: req1_b, op: req1_op, ci: req1_ci};
          grant_id_d = 1'b1;
          ptr_d      = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_f_d  = alu_f;
        res_co_d = alu_co;
        state_d  = RESP;
      end
      RESP: begin
        if (grant_id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= FIRST_GRANT;
      grant_id_q <= 1'b0;
      opnd_q     <= '0;
      res_f_q    <= '0;
      res_co_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      opnd_q     <= opnd_d;
      res_f_q    <= res_f_d;
      res_co_q   <= res_co_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !grant_id_q;
  assign rsp1_valid = (state_q == RESP) &&  grant_id_q;
  assign rsp0_f     = res_f_q;
  assign rsp1_f     = res_f_q;
  assign rsp0_co    = res_co_q;
  assign rsp1_co    = res_co_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a table of single operations followed by
// hand-written contention, fairness, backpressure, reset and pass-through runs.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        req0_ci, req1_ci;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_f, rsp1_f;
  logic        rsp0_co, rsp1_co, busy, grant_id;

  logic [31:0] ref_a, ref_b, ref_f;
  logic [2:0]  ref_op;
  logic        ref_ci, ref_co;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIRST_GRANT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_ci(req0_ci),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_ci(req1_ci),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_f(rsp0_f),
    .rsp0_co(rsp0_co),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_f(rsp1_f),
    .rsp1_co(rsp1_co),
    .busy(busy), .grant_id(grant_id)
  );

  alu_32_bit u_ref (
    .A(ref_a), .B(ref_b), .S0(ref_op[0]), .S1(ref_op[1]), .S2(ref_op[2]),
    .Ci(ref_ci), .F(ref_f), .Co(ref_co)
  );

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ci;
    logic [31:0] f;
    logic        co;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic sel, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op, input logic ci);
    if (sel) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_ci = ci;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_ci = ci;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, grant_id}), 64'(0));
    chk({name, "_data"}, 64'({rsp0_f, rsp1_f}), 64'(0));
    chk({name, "_co"}, 64'({rsp0_co, rsp1_co}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    vecs[0] = '{1'b0, 32'h01010101, 32'h61616161, OP_AND, 1'b0, 32'h01010101, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, OP_ADD, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{1'b1, 32'h0101010F, 32'h61216060, OP_AND, 1'b0, 32'h01010000, 1'b0};
    vecs[3] = '{1'b1, 32'h00000005, 32'h00000003, OP_SUB, 1'b1, 32'h00000002, 1'b1};
    vecs[4] = '{1'b0, 32'h00000003, 32'h00000005, OP_SUB, 1'b1, 32'hFFFFFFFE, 1'b0};
    vecs[5] = '{1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, OP_OR,  1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{1'b0, 32'h12345678, 32'h00000000, OP_NOT, 1'b0, 32'hEDCBA987, 1'b0};
    vecs[7] = '{1'b1, 32'hAAAA5555, 32'hFFFF0000, OP_XOR, 1'b0, 32'h55555555, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, OP_INC, 1'b1, 32'h00000000, 1'b1};
    vecs[9] = '{1'b1, 32'h00000000, 32'h00000000, OP_DEC, 1'b0, 32'hFFFFFFFF, 1'b0};

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    ref_a = '0; ref_b = '0; ref_op = OP_SUB; ref_ci = 1'b1;

    // reset state, including no acceptance while reset is held
    cyc(); cyc();
    chk_all_zero("reset");
    req0_valid = 1'b1; #1;
    chk("reset_ready_masked", 64'(req0_ready), 64'(0));
    req0_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // table of single operations, one requester at a time
    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].sel, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ci); #1;
      chk("vec_ready", 64'(vecs[i].sel ? req1_ready : req0_ready), 64'(1));
      chk("vec_other_ready", 64'(vecs[i].sel ? req0_ready : req1_ready), 64'(0));
      cyc();
      set_req(vecs[i].sel, 1'b0, '0, '0, '0, 1'b0); #1;
      chk("vec_exec_busy", 64'(busy), 64'(1));
      chk("vec_exec_no_rsp", 64'({rsp1_valid, rsp0_valid}), 64'(0));
      cyc();
      chk("vec_rsp_valid", 64'({rsp1_valid, rsp0_valid}), vecs[i].sel ? 64'(2) : 64'(1));
      chk("vec_rsp_f", 64'(vecs[i].sel ? rsp1_f : rsp0_f), 64'(vecs[i].f));
      chk("vec_rsp_co", 64'(vecs[i].sel ? rsp1_co : rsp0_co), 64'(vecs[i].co));
      chk("vec_grant_id", 64'(grant_id), 64'(vecs[i].sel));
      if (vecs[i].sel) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      cyc();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0; #1;
      chk("vec_back_idle", 64'({busy, rsp1_valid, rsp0_valid}), 64'(0));
    end

    // contention right after reset: requester 0 first, requester 1 next
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    set_req(1'b0, 1'b1, 32'h01010101, 32'h61616161, OP_AND, 1'b0);
    set_req(1'b1, 1'b1, 32'h0101010F, 32'h61216060, OP_AND, 1'b0); #1;
    chk("cont_ready_c0", 64'({req1_ready, req0_ready}), 64'(1));
    cyc();
    req0_valid = 1'b0; #1;
    chk("cont_exec_r1_wait", 64'(req1_ready), 64'(0));
    cyc();
    chk("cont_rsp0_valid", 64'({rsp1_valid, rsp0_valid}), 64'(1));
    chk("cont_rsp0_f", 64'(rsp0_f), 64'(32'h01010101));
    rsp0_ready = 1'b1; #1;
    chk("cont_resp_r1_wait", 64'(req1_ready), 64'(0));
    cyc();
    rsp0_ready = 1'b0; #1;
    chk("cont_r1_accept", 64'({req1_ready, req0_ready}), 64'(2));
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("cont_rsp1_valid", 64'({rsp1_valid, rsp0_valid}), 64'(2));
    chk("cont_rsp1_f", 64'(rsp1_f), 64'(32'h01010000));
    rsp1_ready = 1'b1;
    cyc();
    rsp1_ready = 1'b0;

    // fairness: both requesters always valid, responses always taken
    set_req(1'b0, 1'b1, 32'h01010101, 32'h61616161, OP_AND, 1'b0);
    set_req(1'b1, 1'b1, 32'h0101010F, 32'h61216060, OP_AND, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      automatic int g = (c / 3) % 2;
      #1;
      if (c % 3 == 0)
        chk("fair_ready", 64'({req1_ready, req0_ready}), (g != 0) ? 64'(2) : 64'(1));
      else
        chk("fair_no_ready", 64'({req1_ready, req0_ready}), 64'(0));
      if (c % 3 == 1) chk("fair_grant_id", 64'(grant_id), 64'(g));
      if (c % 3 == 2) begin
        chk("fair_rsp_valid", 64'({rsp1_valid, rsp0_valid}), (g != 0) ? 64'(2) : 64'(1));
        chk("fair_rsp_f", 64'((g != 0) ? rsp1_f : rsp0_f),
            (g != 0) ? 64'(32'h01010000) : 64'(32'h01010101));
      end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // backpressure on requester 1 while requester 0 waits
    set_req(1'b1, 1'b1, 32'h0101010F, 32'h61216060, OP_AND, 1'b0); #1;
    chk("bp_accept_r1", 64'({req1_ready, req0_ready}), 64'(2));
    cyc();
    req1_valid = 1'b0;
    set_req(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, OP_ADD, 1'b0); #1;
    chk("bp_exec_r0_wait", 64'(req0_ready), 64'(0));
    cyc();
    for (int c = 2; c < 7; c++) begin
      #1;
      chk("bp_hold_valid", 64'(rsp1_valid), 64'(1));
      chk("bp_hold_f", 64'(rsp1_f), 64'(32'h01010000));
      chk("bp_hold_r0_wait", 64'(req0_ready), 64'(0));
      cyc();
    end
    rsp1_ready = 1'b1; #1;
    chk("bp_release_valid", 64'(rsp1_valid), 64'(1));
    chk("bp_release_r0_wait", 64'(req0_ready), 64'(0));
    cyc();
    rsp1_ready = 1'b0; #1;
    chk("bp_after_valid", 64'(rsp1_valid), 64'(0));
    chk("bp_after_r0_ready", 64'(req0_ready), 64'(1));
    cyc();
    req0_valid = 1'b0;
    cyc();
    chk("bp_r0_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'(1));
    chk("bp_r0_rsp", 64'({rsp0_co, rsp0_f}), 64'({1'b1, 32'h00000000}));
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;

    // reset during EXEC after a requester-0 win (pointer would favour 1)
    set_req(1'b0, 1'b1, 32'h01010101, 32'h61616161, OP_AND, 1'b0); #1;
    chk("rst_accept_r0", 64'(req0_ready), 64'(1));
    cyc();
    req0_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk("rst_in_exec", 64'(busy), 64'(1));
    cyc();
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("rst_no_rsp", 64'({busy, rsp1_valid, rsp0_valid}), 64'(0));
    end
    set_req(1'b0, 1'b1, 32'h00000003, 32'h00000005, OP_SUB, 1'b1);
    set_req(1'b1, 1'b1, 32'h00000005, 32'h00000003, OP_SUB, 1'b1); #1;
    chk("rst_ptr_first", 64'({req1_ready, req0_ready}), 64'(1));
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    chk("rst_post_rsp", 64'({rsp0_valid, rsp0_co, rsp0_f}), 64'({2'b10, 32'hFFFFFFFE}));
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;

    // pass-through against a directly driven ALU and an arithmetic model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 0) rb = ra;
      ref_a = ra; ref_b = rb; ref_op = OP_SUB; ref_ci = 1'b1;
      set_req(1'b1, 1'b1, ra, rb, OP_SUB, 1'b1); #1;
      chk("pt_ready", 64'(req1_ready), 64'(1));
      cyc();
      req1_valid = 1'b0;
      cyc();
      chk("pt_valid", 64'(rsp1_valid), 64'(1));
      chk("pt_ref_f", 64'(rsp1_f), 64'(ref_f));
      chk("pt_ref_co", 64'(rsp1_co), 64'(ref_co));
      chk("pt_model", 64'({rsp1_co, rsp1_f}), 64'({ra >= rb, ra - rb}));
      rsp1_ready = 1'b1;
      cyc();
      rsp1_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
